// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit words and
// writes them into the fetch-stage instruction memory, holding the core in
// reset until a complete image has been loaded.
// Ports: clk/rst (sync, active-high); start/len_words load request;
//        s_valid/s_data/s_ready byte stream; mem_we/mem_waddr/mem_wdata
//        memory write port; core_hold, busy, done (pulse), err (pulse).
module imem_loader #(
  parameter int DEPTH_WORDS = 8,
  parameter int WADDR_W     = $clog2(DEPTH_WORDS),
  parameter int TIMEOUT     = 1024,
  parameter bit BOOT_VALID  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WADDR_W:0]   len_words,
  input  logic               s_valid,
  input  logic [7:0]         s_data,
  output logic               s_ready,
  output logic               mem_we,
  output logic [WADDR_W-1:0] mem_waddr,
  output logic [31:0]        mem_wdata,
  output logic               core_hold,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [WADDR_W:0]   len_q;
  logic [WADDR_W-1:0] word_cnt;
  logic [1:0]         byte_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [31:0]        word_q;
  logic               image_valid, image_valid_n;
  logic               core_hold_q;
  logic               done_q, err_q;

  logic hs;
  logic len_ok;
  logic last_word;
  logic tmo_hit;

  assign hs        = s_valid && (state == RECV);
  assign len_ok    = (len_words != '0) &&
                     (len_words <= (WADDR_W+1)'(DEPTH_WORDS));
  assign last_word = ({1'b0, word_cnt} == (len_q - {{WADDR_W{1'b0}}, 1'b1}));
  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT - 1));

  // Next-state and next-flag logic.
  always_comb begin
    state_n       = state;
    image_valid_n = image_valid;
    case (state)
      IDLE: begin
        if (start && len_ok) begin
          state_n = RECV;
        end
      end
      RECV: begin
        // A handshake always wins over the timeout threshold.
        if (hs) begin
          if (byte_cnt == 2'd3) state_n = WRITE;
        end else if (tmo_hit) begin
          state_n = ABORT;
        end
      end
      WRITE: begin
        state_n = last_word ? DONE : RECV;
      end
      DONE:    state_n = IDLE;
      ABORT:   state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (state == IDLE && state_n == RECV) begin
      image_valid_n = 1'b0;
    end else if (state_n == DONE) begin
      image_valid_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      len_q       <= '0;
      word_cnt    <= '0;
      byte_cnt    <= '0;
      tmo_cnt     <= '0;
      word_q      <= '0;
      image_valid <= BOOT_VALID;
      core_hold_q <= ~BOOT_VALID;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_n;
      image_valid <= image_valid_n;
      // Hold is computed from next-state values so the output is a plain
      // flop and cannot glitch on state-encoding transitions.
      core_hold_q <= (state_n != IDLE) || !image_valid_n;
      done_q      <= (state_n == DONE);
      err_q       <= (state_n == ABORT) || (state == IDLE && start && !len_ok);

      case (state)
        IDLE: begin
          if (start && len_ok) begin
            len_q    <= len_words;
            word_cnt <= '0;
            byte_cnt <= '0;
            tmo_cnt  <= '0;
          end
        end
        RECV: begin
          if (hs) begin
            word_q[{byte_cnt, 3'b000} +: 8] <= s_data;
            byte_cnt <= byte_cnt + 2'd1;
            tmo_cnt  <= '0;
          end else begin
            tmo_cnt  <= tmo_cnt + {{(TMO_W-1){1'b0}}, 1'b1};
          end
        end
        WRITE: begin
          if (!last_word) begin
            word_cnt <= word_cnt + {{(WADDR_W-1){1'b0}}, 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

  assign s_ready   = (state == RECV);
  assign mem_we    = (state == WRITE);
  assign mem_waddr = (state == WRITE) ? word_cnt : '0;
  assign mem_wdata = (state == WRITE) ? word_q : '0;
  assign busy      = (state != IDLE);
  assign core_hold = core_hold_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int DW  = 8;
  localparam int AW  = 3;
  localparam int TMO = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   len_words;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          core_hold;
  logic          busy;
  logic          done;
  logic          err;

  // Second instance with BOOT_VALID=0 sharing the same stimulus.
  logic          b_s_ready, b_mem_we, b_core_hold, b_busy, b_done, b_err;
  logic [AW-1:0] b_mem_waddr;
  logic [31:0]   b_mem_wdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH_WORDS(DW), .TIMEOUT(TMO), .BOOT_VALID(1'b1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .len_words(len_words),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .busy(busy), .done(done), .err(err)
  );

  imem_loader #(.DEPTH_WORDS(DW), .TIMEOUT(TMO), .BOOT_VALID(1'b0)) u_dut_nb (
    .clk(clk), .rst(rst), .start(start), .len_words(len_words),
    .s_valid(s_valid), .s_data(s_data), .s_ready(b_s_ready),
    .mem_we(b_mem_we), .mem_waddr(b_mem_waddr), .mem_wdata(b_mem_wdata),
    .core_hold(b_core_hold), .busy(b_busy), .done(b_done), .err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends four bytes of w (byte 0 first) at full rate; returns in the
  // cycle after the last byte, which is the WRITE cycle.
  task automatic send_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      s_valid = 1'b1;
      s_data  = w[8*b +: 8];
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_mem_we"},  32'(mem_we),  32'd0);
    chk({tag, "_waddr"},   32'(mem_waddr), 32'd0);
    chk({tag, "_wdata"},   mem_wdata,    32'd0);
    chk({tag, "_busy"},    32'(busy),    32'd0);
    chk({tag, "_done"},    32'(done),    32'd0);
    chk({tag, "_err"},     32'(err),     32'd0);
  endtask

  initial begin
    logic [31:0] w;
    int          we_seen;
    int          gap;

    rst = 1'b1; start = 1'b0; len_words = '0; s_valid = 1'b0; s_data = '0;
    tick(); tick();

    // Reset state (while reset held and after release).
    chk_idle_outputs("rst");
    chk("rst_hold_bv1", 32'(core_hold),   32'd0);
    chk("rst_hold_bv0", 32'(b_core_hold), 32'd1);
    rst = 1'b0;
    tick();
    chk_idle_outputs("post_rst");

    // Two-word load at full rate. Current cycle is T.
    start = 1'b1; len_words = 4'd2;
    tick();                                            // T+1
    start = 1'b0;
    chk("l2_s_ready_T1", 32'(s_ready), 32'd1);
    chk("l2_busy_T1",    32'(busy),    32'd1);
    chk("l2_hold_T1",    32'(core_hold), 32'd1);
    send_word(32'h0000_0013);                          // T+5
    chk("l2_we_T5",    32'(mem_we),    32'd1);
    chk("l2_addr_T5",  32'(mem_waddr), 32'd0);
    chk("l2_data_T5",  mem_wdata,      32'h0000_0013);
    chk("l2_rdy_T5",   32'(s_ready),   32'd0);
    tick();                                            // T+6
    chk("l2_we_T6",    32'(mem_we),    32'd0);
    send_word(32'h0010_0093);                          // T+10
    chk("l2_we_T10",   32'(mem_we),    32'd1);
    chk("l2_addr_T10", 32'(mem_waddr), 32'd1);
    chk("l2_data_T10", mem_wdata,      32'h0010_0093);
    chk("l2_done_T10", 32'(done),      32'd0);
    tick();                                            // T+11
    chk("l2_done_T11", 32'(done),      32'd1);
    chk("l2_err_T11",  32'(err),       32'd0);
    chk("l2_hold_T11", 32'(core_hold), 32'd1);
    tick();                                            // T+12
    chk("l2_done_T12", 32'(done),      32'd0);
    chk("l2_hold_T12", 32'(core_hold), 32'd0);
    chk("l2_busy_T12", 32'(busy),      32'd0);
    chk("l2_hold_bv0", 32'(b_core_hold), 32'd0);

    // Bad lengths: 0 and DEPTH_WORDS+1.
    start = 1'b1; len_words = 4'd0;
    tick();
    start = 1'b0;
    chk("len0_err",  32'(err),    32'd1);
    chk("len0_busy", 32'(busy),   32'd0);
    chk("len0_we",   32'(mem_we), 32'd0);
    tick();
    chk("len0_err_clr", 32'(err), 32'd0);
    chk("len0_hold",    32'(core_hold), 32'd0);
    start = 1'b1; len_words = 4'd9;
    tick();
    start = 1'b0;
    chk("len9_err",  32'(err),    32'd1);
    chk("len9_busy", 32'(busy),   32'd0);
    chk("len9_rdy",  32'(s_ready), 32'd0);
    tick();
    chk("len9_err_clr", 32'(err), 32'd0);

    // Timeout: two bytes, then silence.
    start = 1'b1; len_words = 4'd1;
    tick();
    start = 1'b0;
    s_valid = 1'b1; s_data = 8'hAA; tick();
    s_valid = 1'b1; s_data = 8'hBB; tick();            // L+1 (L = last byte)
    s_valid = 1'b0;
    we_seen = 0;
    for (int j = 0; j < TMO - 1; j++) begin
      if (mem_we || err) we_seen++;
      tick();
    end                                                // L+TMO
    if (mem_we || err) we_seen++;
    chk("tmo_quiet", 32'(we_seen), 32'd0);
    chk("tmo_rdy_last", 32'(s_ready), 32'd1);
    tick();                                            // L+TMO+1
    chk("tmo_err",  32'(err),       32'd1);
    chk("tmo_done", 32'(done),      32'd0);
    chk("tmo_we",   32'(mem_we),    32'd0);
    chk("tmo_hold", 32'(core_hold), 32'd1);
    tick();
    chk("tmo_err_clr", 32'(err),       32'd0);
    chk("tmo_busy",    32'(busy),      32'd0);
    chk("tmo_hold_idle", 32'(core_hold), 32'd1);

    // Good load after abort.
    start = 1'b1; len_words = 4'd1;
    tick();
    start = 1'b0;
    send_word(32'hDEAD_BEEF);
    chk("rec_we",   32'(mem_we),    32'd1);
    chk("rec_addr", 32'(mem_waddr), 32'd0);
    chk("rec_data", mem_wdata,      32'hDEAD_BEEF);
    tick();
    chk("rec_done", 32'(done), 32'd1);
    tick();
    chk("rec_hold", 32'(core_hold), 32'd0);

    // Full-depth load with random stream gaps and stray start pulses.
    start = 1'b1; len_words = 4'd8;
    tick();
    start = 1'b0;
    for (int wi = 0; wi < DW; wi++) begin
      w = {8'(4*wi+3), 8'(4*wi+2), 8'(4*wi+1), 8'(4*wi)};
      for (int b = 0; b < 4; b++) begin
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          s_valid   = 1'b0;
          start     = g[0];
          len_words = 4'd1;
          if (mem_we) chk("rnd_we_in_gap", 32'(mem_we), 32'd0);
          tick();
        end
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'(4*wi + b);
        tick();
      end
      s_valid = 1'b1;   // offered but must not be taken in WRITE
      s_data  = 8'hFF;
      chk($sformatf("rnd_we_%0d",   wi), 32'(mem_we),    32'd1);
      chk($sformatf("rnd_addr_%0d", wi), 32'(mem_waddr), 32'(wi));
      chk($sformatf("rnd_data_%0d", wi), mem_wdata,      w);
      chk($sformatf("rnd_rdy_%0d",  wi), 32'(s_ready),   32'd0);
      tick();
      s_valid = 1'b0;
    end
    chk("rnd_done", 32'(done), 32'd1);
    tick();
    chk("rnd_hold", 32'(core_hold), 32'd0);
    chk("rnd_busy", 32'(busy),      32'd0);

    // Reset in the middle of word 1.
    start = 1'b1; len_words = 4'd2;
    tick();
    start = 1'b0;
    send_word(32'h1111_1111);
    tick();
    s_valid = 1'b1; s_data = 8'h22; tick();
    s_valid = 1'b1; s_data = 8'h33; tick();
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk_idle_outputs("mid_rst");
    chk("mid_rst_hold_bv1", 32'(core_hold),   32'd0);
    chk("mid_rst_hold_bv0", 32'(b_core_hold), 32'd1);
    rst = 1'b0;
    tick();
    chk("mid_rst_done_after", 32'(done), 32'd0);
    chk("mid_rst_err_after",  32'(err),  32'd0);
    start = 1'b1; len_words = 4'd1;
    tick();
    start = 1'b0;
    send_word(32'hCAFE_F00D);
    chk("post_rst_we",   32'(mem_we),    32'd1);
    chk("post_rst_addr", 32'(mem_waddr), 32'd0);
    chk("post_rst_data", mem_wdata,      32'hCAFE_F00D);
    tick();
    chk("post_rst_done", 32'(done), 32'd1);
    tick();
    chk("post_rst_hold",     32'(core_hold),   32'd0);
    chk("post_rst_hold_bv0", 32'(b_core_hold), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Sequences writes into the instruction memory of the fetch stage. It accepts a byte stream from a host link (UART/debug bridge) and assembles little-endian 32-bit words. It writes one word per cycle into the memory's write port and holds the core in reset while an image is incomplete. It sits beside the fetch-stage instruction memory and owns that memory's write side and the core's hold signal.

## Interface
- DEPTH_WORDS, 8: instruction memory depth in 32-bit words (32 bytes at default).
- WADDR_W, $clog2(DEPTH_WORDS): word address width.
- TIMEOUT, 1024: consecutive RECV cycles without an accepted byte before abort.
- BOOT_VALID, 1: memory is preloaded at configuration; the core runs out of reset.

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  load request pulse; sampled only in IDLE
- len_words  in  WADDR_W+1  number of words to load; sampled with start
- s_valid  in  1  byte stream valid
- s_data  in  8  byte stream data
- s_ready  out  1  byte accepted when s_valid & s_ready
- mem_we  out  1  instruction memory word write enable
- mem_waddr  out  WADDR_W  word address; byte address = {mem_waddr, 2'b00}
- mem_wdata  out  32  write word; byte 0 in [7:0]
- core_hold  out  1  holds the core (PC/pipeline) in reset
- busy  out  1  a load session is active
- done  out  1  one-cycle pulse: image loaded successfully
- err  out  1  one-cycle pulse: bad length or timeout abort

## Operation
- States: IDLE, RECV, WRITE, DONE, ABORT. The state register is binary encoded.
- image_valid flag:
  - Set to BOOT_VALID on reset.
  - Cleared on entering RECV from IDLE.
  - Set on entering DONE.
  - Unaffected by ABORT.
- core_hold = (state != IDLE) | ~image_valid. The output is registered-equivalent and glitch-free.
- busy = (state != IDLE).
- IDLE:
  - s_ready=0 and mem_we=0.
  - start with 1 <= len_words <= DEPTH_WORDS: latch len_words, clear word_cnt, byte_cnt and tmo_cnt, go to RECV.
  - start with len_words == 0 or > DEPTH_WORDS: err=1 for one cycle, stay IDLE, image_valid unchanged.
- RECV:
  - s_ready=1.
  - Each handshake writes s_data into shift register byte lane byte_cnt, increments byte_cnt (2 bits) and clears tmo_cnt.
  - A handshake with byte_cnt==3 moves to WRITE.
  - A cycle with no handshake increments tmo_cnt. When tmo_cnt reaches TIMEOUT-1 with no handshake, go to ABORT.
- WRITE:
  - s_ready=0, mem_we=1, mem_waddr=word_cnt, mem_wdata=assembled word.
  - If word_cnt == len-1, go to DONE. Otherwise increment word_cnt and return to RECV.
- DONE: done=1 for one cycle, set image_valid, go to IDLE.
- ABORT: err=1 for one cycle, go to IDLE. Words already written stay in memory, but image_valid=0 keeps the core held.
- start outside IDLE is ignored.
- Bytes beyond len_words*4 are not accepted because s_ready is 0 in IDLE.
- mem_waddr and mem_wdata are don't-care when mem_we=0. They are driven 0 in IDLE.

## Timing
- Reset values: state=IDLE, s_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, busy=0, done=0, err=0, core_hold=~BOOT_VALID.
- Reset mid-session aborts immediately with no err pulse. A partial image is not marked valid unless BOOT_VALID=1.
- start sampled at cycle T gives RECV from T+1. s_ready is asserted in the same cycle as RECV.
- At full stream rate each word takes 4 RECV cycles plus 1 WRITE cycle. For N words:
  - WRITE cycles occur at T+5k for k=1..N.
  - done is high at T+5N+1.
  - core_hold falls at T+5N+2.
- Stalls in s_valid extend the session 1:1.
- Timeout fires after exactly TIMEOUT consecutive non-accepting RECV cycles. ABORT (err=1) is the following cycle.
- A handshake and the timeout threshold in the same cycle: the handshake wins and tmo_cnt clears.
- done and err are never high together.

## Test plan
- Reset, BOOT_VALID=1 -> core_hold=0, busy=0, all pulses 0. With BOOT_VALID=0 -> core_hold=1 until the first DONE.
- start, len_words=2; stream 0x13,0x00,0x00,0x00,0x93,0x00,0x10,0x00 at full rate from T+1:
  - mem_we at T+5 with addr 0, data 0x00000013.
  - mem_we at T+10 with addr 1, data 0x00100093.
  - done at T+11, core_hold=0 at T+12.
- len_words=0 and len_words=DEPTH_WORDS+1 -> err pulse at T+1, busy stays 0, no mem_we.
- len_words=1, send 2 bytes, then hold s_valid=0 for TIMEOUT cycles -> err pulse exactly TIMEOUT+1 cycles after the last byte, core_hold stays 1, no mem_we. A following good load completes normally.
- Randomized s_valid gaps below TIMEOUT with len_words=DEPTH_WORDS:
  - All 8 words are written at addresses 0..7 in order.
  - s_ready is never high in WRITE.
  - start pulses during the session are ignored.
- Assert rst during RECV of word 1 -> next cycle all outputs at reset values, no done/err. A new start loads cleanly.
